msx_bus_master: RTL
===================

// Module: msx_bus_master
// PURPOSE
//  Z80-timed MSX cartridge-slot bus initiator. Turns single transaction requests into memory
//  read/write, opcode fetch (with refresh) and I/O cycles with correct strobe ordering, WAIT
//  insertion and SLTSL select. Drives cartridge mappers/ROMs from the host side (dumper,
//  bring-up rig, bench master for mapper RTL).
// PARAMETERS
//  HALF      1    SLOTCLK cycles per Z80 half-T-state (>=1); one T-state = 2*HALF clocks
//  WAIT_MAX  255  max wait states inserted (auto I/O TW excluded) before forced completion
// PORTS
//  SLOTCLK     in   1   single clock; all logic on posedge
//  RESET       in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   high only in IDLE; transfer = req_valid & req_ready
//  req_type    in   2   00 mem read, 01 mem write, 10 opcode fetch, 11 I/O
//  req_write   in   1   I/O direction (1=OUT); ignored for other types
//  req_addr    in   16  bus address
//  req_wdata   in   8   write data
//  rsp_valid   out  1   one-clock pulse at completion
//  rsp_rdata   out  8   read/fetch/IN data; 0 for writes; held until next rsp_valid
//  rsp_err     out  1   valid with rsp_valid; 1 = WAIT_MAX exceeded
//  A           out  16  address bus
//  D_OUT       out  8   data out;  D_OE out 1 data bus drive enable
//  D_IN        in   8   data in (synchronous to SLOTCLK)
//  WAIT        in   1   active-low wait (synchronous to SLOTCLK)
//  RD WR MREQ IORQ M1 RFSH SLTSL   out 1 each, active-low strobes
// BEHAVIOUR
//  Reset (async): state IDLE, all strobes 1, D_OE 0, A 0, D_OUT 0, R counter 0, rsp_* 0.
//   Reset mid-cycle: strobes release immediately, no rsp_valid for the aborted cycle.
//  States: IDLE, T1, T2, TW, T3, T4; each non-IDLE state = 2*HALF clocks, halves a/b.
//  Accept in IDLE: latch request, A <= req_addr, next clock enters T1a. req_ready 0 until IDLE.
//  Mem read:  T1 T2 T3. MREQ,RD,SLTSL low T1b..T3a. D_IN captured last clock of T3a.
//  Mem write: T1 T2 T3. MREQ,SLTSL low T1b..T3a; WR low T2a..T3a; D_OE high T1b..T3b.
//  I/O: T1 T2 TW(auto) T3. IORQ and RD (IN) or WR (OUT) low T2a..T3a; SLTSL stays 1;
//   OUT: D_OE high T1b..T3b. IN: D_IN captured last clock of T3a.
//  Fetch: T1 T2 T3 T4. M1 low T1a..T2b; MREQ,RD,SLTSL low T1b..T2b; D_IN captured last clock
//   of T2b (or last TW). T3/T4: A <= {8'h00,1'b0,R[6:0]}, RFSH low T3a..T4b, MREQ low
//   T3b..T4a, RD/SLTSL stay 1. R increments (7-bit wrap 7F->00) once per fetch, at T4 exit.
//  WAIT: sampled last clock of T2 (I/O: last clock of auto TW) and of every inserted TW.
//   Low -> insert TW (strobes hold state), count++. Count == WAIT_MAX while still low ->
//   stop inserting, proceed to T3 (fetch: capture), set rsp_err=1.
//  Completion: after last state, return to IDLE; rsp_valid=1 for exactly the first IDLE
//   clock; req_ready high same clock. Min 1 IDLE clock between cycles.
//  A stable from T1a to end of cycle (refresh address during T3/T4 of fetch).
// TESTING
//  HALF=1, mem write 6000h/05h -> MREQ,SLTSL low clk1-4, WR low clk2-4, D_OE clk1-5, rsp_valid clk6
//  Mem read 4000h, D_IN=A5h, WAIT=1 -> RD low clk1-4, rsp_rdata=A5h, rsp_err=0, 6-clk cycle
//  Mem read with WAIT low 3 samples -> 3 TW inserted (+6 clks), data captured after last TW
//  Fetch 0000h x129 from reset -> M1 clk0-3, RFSH clk4-7, refresh A low byte 00..7F then wraps 00
//  I/O OUT 98h/3Ch -> IORQ,WR low clk2-6, SLTSL never low; WAIT_MAX=2, WAIT held 0 -> rsp_err=1
//  RESET pulsed during T2 of write -> strobes high async, no rsp_valid, next request accepted

Source files
------------

// File: rtl/msx_bus_master.sv
// Z80-timed MSX cartridge-slot bus initiator: sequences memory, opcode-fetch/refresh and I/O
// cycles with WAIT insertion, and returns one response per accepted request.
module msx_bus_master #(
    parameter int unsigned HALF     = 1,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        SLOTCLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] A,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic [7:0]  D_IN,
    input  logic        WAIT,
    output logic        RD,
    output logic        WR,
    output logic        MREQ,
    output logic        IORQ,
    output logic        M1,
    output logic        RFSH,
    output logic        SLTSL
);
    localparam int unsigned HCW = $clog2(2 * HALF);
    localparam int unsigned WCW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_TW   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;

    localparam logic [1:0] TY_MRD   = 2'b00;
    localparam logic [1:0] TY_MWR   = 2'b01;
    localparam logic [1:0] TY_FETCH = 2'b10;
    localparam logic [1:0] TY_IO    = 2'b11;

    logic [2:0]     state_q, state_d;
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [1:0]     type_q, type_d;
    logic           iow_q, iow_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           err_q, err_d;
    logic [7:0]     cap_q, cap_d;
    logic [6:0]     r_q, r_d;
    logic [15:0]    a_q, a_d;
    logic [7:0]     dout_q, dout_d;
    logic           doe_q, doe_d;
    logic           rd_q, rd_d, wr_q, wr_d, mreq_q, mreq_d, iorq_q, iorq_d;
    logic           m1_q, m1_d, rfsh_q, rfsh_d, sltsl_q, sltsl_d;
    logic           ready_q, ready_d, rv_q, rv_d, rerr_q, rerr_d;
    logic [7:0]     rdata_q, rdata_d;

    logic last, a_last, is_fetch, sample, to_t3, done;
    logic halfb, t1, t1b, mid, t3, t3a, t3b, t4, t4a;

    // State, datapath and registered bus outputs
    always_ff @(posedge SLOTCLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            type_q  <= 2'b00;
            iow_q   <= 1'b0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            cap_q   <= 8'h00;
            r_q     <= 7'h00;
            a_q     <= 16'h0000;
            dout_q  <= 8'h00;
            doe_q   <= 1'b0;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            mreq_q  <= 1'b1;
            iorq_q  <= 1'b1;
            m1_q    <= 1'b1;
            rfsh_q  <= 1'b1;
            sltsl_q <= 1'b1;
            ready_q <= 1'b1;
            rv_q    <= 1'b0;
            rerr_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            type_q  <= type_d;
            iow_q   <= iow_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            cap_q   <= cap_d;
            r_q     <= r_d;
            a_q     <= a_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mreq_q  <= mreq_d;
            iorq_q  <= iorq_d;
            m1_q    <= m1_d;
            rfsh_q  <= rfsh_d;
            sltsl_q <= sltsl_d;
            ready_q <= ready_d;
            rv_q    <= rv_d;
            rerr_q  <= rerr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        type_d  = type_q;
        iow_d   = iow_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        cap_d   = cap_q;
        r_d     = r_q;
        a_d     = a_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        rv_d    = 1'b0;
        rerr_d  = 1'b0;
        sample  = 1'b0;
        to_t3   = 1'b0;
        done    = 1'b0;

        last     = (hcnt_q == HCW'(2 * HALF - 1));
        a_last   = (hcnt_q == HCW'(HALF - 1));
        is_fetch = (type_q == TY_FETCH);

        if (state_q != S_IDLE) begin
            hcnt_d = last ? '0 : hcnt_q + HCW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = S_T1;
                    hcnt_d  = '0;
                    type_d  = req_type;
                    iow_d   = req_write;
                    a_d     = req_addr;
                    dout_d  = req_wdata;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_T1: if (last) state_d = S_T2;
            S_T2: begin
                // I/O always gets one automatic wait state before WAIT is looked at
                if (last) begin
                    if (type_q == TY_IO) state_d = S_TW;
                    else                 sample  = 1'b1;
                end
            end
            S_TW: if (last) sample = 1'b1;
            S_T3: begin
                if (!is_fetch && a_last) cap_d = D_IN;
                if (last) begin
                    if (is_fetch) state_d = S_T4;
                    else          done    = 1'b1;
                end
            end
            S_T4: begin
                if (last) begin
                    r_d  = r_q + 7'd1;
                    done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Stop stretching once WAIT_MAX waits were inserted; completion is then flagged as error
        if (sample) begin
            if (!WAIT && (wcnt_q != WCW'(WAIT_MAX))) begin
                state_d = S_TW;
                wcnt_d  = wcnt_q + WCW'(1);
            end else begin
                err_d = !WAIT;
                to_t3 = 1'b1;
            end
        end

        if (to_t3) begin
            state_d = S_T3;
            if (is_fetch) begin
                cap_d = D_IN;
                a_d   = {8'h00, 1'b0, r_q};
            end
        end

        if (done) begin
            state_d = S_IDLE;
            rv_d    = 1'b1;
            rerr_d  = err_q;
            rdata_d = ((type_q == TY_MWR) || ((type_q == TY_IO) && iow_q)) ? 8'h00 : cap_q;
        end

        // Strobes are decoded from the next state so the registered pins line up with it
        halfb = (hcnt_d >= HCW'(HALF));
        t1    = (state_d == S_T1);
        t1b   = t1 && halfb;
        mid   = (state_d == S_T2) || (state_d == S_TW);
        t3    = (state_d == S_T3);
        t3a   = t3 && !halfb;
        t3b   = t3 && halfb;
        t4    = (state_d == S_T4);
        t4a   = t4 && !halfb;

        rd_d    = 1'b1;
        wr_d    = 1'b1;
        mreq_d  = 1'b1;
        iorq_d  = 1'b1;
        m1_d    = 1'b1;
        rfsh_d  = 1'b1;
        sltsl_d = 1'b1;
        doe_d   = 1'b0;

        case (type_d)
            TY_MRD: begin
                mreq_d  = !(t1b || mid || t3a);
                rd_d    = !(t1b || mid || t3a);
                sltsl_d = !(t1b || mid || t3a);
            end
            TY_MWR: begin
                mreq_d  = !(t1b || mid || t3a);
                sltsl_d = !(t1b || mid || t3a);
                wr_d    = !(mid || t3a);
                doe_d   = t1b || mid || t3;
            end
            TY_FETCH: begin
                m1_d    = !(t1 || mid);
                rd_d    = !(t1b || mid);
                sltsl_d = !(t1b || mid);
                mreq_d  = !(t1b || mid || t3b || t4a);
                rfsh_d  = !(t3 || t4);
            end
            default: begin
                iorq_d = !(mid || t3a);
                if (iow_d) begin
                    wr_d  = !(mid || t3a);
                    doe_d = t1b || mid || t3;
                end else begin
                    rd_d = !(mid || t3a);
                end
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    assign req_ready = ready_q;
    assign rsp_valid = rv_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;
    assign A         = a_q;
    assign D_OUT     = dout_q;
    assign D_OE      = doe_q;
    assign RD        = rd_q;
    assign WR        = wr_q;
    assign MREQ      = mreq_q;
    assign IORQ      = iorq_q;
    assign M1        = m1_q;
    assign RFSH      = rfsh_q;
    assign SLTSL     = sltsl_q;

endmodule
